spk_idx_dec: RTL and testbench
==============================

Name: spk_idx_dec

Overview:
- Sits directly downstream of the 32-bit sparse index encoder.
- Consumes the encoder's 6-bit token stream and rebuilds absolute neuron addresses for the synaptic-weight fetch stage.
  - Data token {0,off}: off is the distance from the previous spike in the word, or the absolute bit index for the first spike.
  - End token {1,tail}: tail is the distance from the last spike to bit 31.
- Tracks word position across the WORDS words of one timestep and flags timestep completion.

Parameters:
- WORDS, 8, number of 32-bit spike words per timestep (>=1).
- ADDR_W, 8, address width; must satisfy 2^ADDR_W >= WORDS*32.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- ipt_valid  in  1  token valid from encoder.
- ipt_ready  out  1  token accepted when ipt_valid && ipt_ready.
- enc  in  6  token: [5] end flag, [4:0] offset or tail.
- opt_valid  out  1  addr valid.
- opt_ready  in  1  downstream accepts addr.
- addr  out  ADDR_W  absolute neuron address = word_idx*32 + bit position.
- step_done  out  1  one-cycle pulse when the timestep is complete.
- spk_cnt  out  ADDR_W+1  spike count of the last completed timestep.
- fmt_err  out  1  sticky token-format error.

Behaviour:
- Reset (async, rst_n=0):
  - state=RUN, bit_acc=0, word_idx=0, first=1, run_cnt=0.
  - opt_valid=0, addr=0, step_done=0, spk_cnt=0, fmt_err=0.
  - Reset mid-word discards all partial state. The output register is emptied; no addr or step_done is emitted for the aborted word.
- bit_acc is 6 bits. word_idx is clog2(WORDS) bits (min 1). run_cnt is ADDR_W+1 bits.
- Output register is one stage:
  - Loads on data-token accept.
  - Holds addr stable while opt_valid && !opt_ready.
  - Clears opt_valid on opt_ready when no new load occurs.
- States: RUN and DRAIN.
- RUN:
  - ipt_ready = !opt_valid || opt_ready (combinational). Full throughput of one token per cycle.
  - Data token accept, with sum = bit_acc + off (6 bits):
    - addr <= word_idx*32 + sum[4:0]; opt_valid <= 1.
    - bit_acc <= sum; first <= 0; run_cnt <= run_cnt + 1.
  - End token accept:
    - No output.
    - bit_acc <= 0; first <= 1.
    - If word_idx == WORDS-1: word_idx <= 0 and state -> DRAIN.
    - Otherwise: word_idx <= word_idx + 1.
- DRAIN:
  - ipt_ready=0.
  - When opt_valid==0 (or opt_valid && opt_ready this cycle), in the same cycle:
    - Pulse step_done; spk_cnt <= run_cnt (or run_cnt+1 if the last addr retires in the same cycle — not possible, run_cnt is already final).
    - run_cnt <= 0; state -> RUN.
- Latency: data token accept -> addr valid the next cycle. Final end token accept -> step_done no earlier than 1 cycle later, after the output has drained.
- An all-zero word (single token {1,31}) only advances word_idx.
- Simultaneous output retire and new load: the new value wins and opt_valid stays 1.
- WORDS=1: every end token enters DRAIN.

Optional Feature:
- Macro: SPK_IDX_DEC_CHK_EN.
- Defined: fmt_err is set (sticky until reset) when any of these occurs:
  - A data token has sum > 31.
  - A non-first data token has off == 0 (duplicate spike).
  - An end token has bit_acc + tail != 31.
- After an error, decoding continues unchanged using sum[4:0].
- Undefined: check logic is absent and fmt_err is tied to 0.

Test Plan:
- WORDS=1, tokens 0x00,0x05,0x1A,0x20 -> addr 0,5,31 in order; step_done one cycle after the output drains; spk_cnt=3; fmt_err=0.
- WORDS=2, tokens 0x3F, 0x03, 0x3C -> single addr 35; step_done pulses once; spk_cnt=1.
- Backpressure: opt_ready=0 for 3 cycles with tokens 0x02,0x04 pending -> addr=2 held stable, ipt_ready=0; on release, addr 2 then 6 with no loss or duplication.
- CHK_EN defined, WORDS=1, tokens 0x05,0x21 -> fmt_err=1 after the end token and remains 1; step_done still pulses.
- Reset asserted after tokens 0x04,0x01, then tokens 0x07,0x38 -> after reset, addr=7 (not 12); spk_cnt=1.
- Back-to-back timesteps, WORDS=1, tokens 0x3F then 0x00,0x3F -> step_done pulses twice; spk_cnt=0 then 1; addr 0.

Source files
------------

// File: rtl/spk_idx_dec.sv
// Sparse spike-index decoder: turns the encoder's 6-bit offset/end token stream
// back into absolute neuron addresses and flags the end of each timestep.
// Optional token-format checking is enabled by defining SPK_IDX_DEC_CHK_EN;
// without it fmt_err is tied low and no check logic is built.
module spk_idx_dec #(
    parameter int unsigned WORDS  = 8,
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ipt_valid,
    output logic              ipt_ready,
    input  logic [5:0]        enc,
    output logic              opt_valid,
    input  logic              opt_ready,
    output logic [ADDR_W-1:0] addr,
    output logic              step_done,
    output logic [ADDR_W:0]   spk_cnt,
    output logic              fmt_err
);

    localparam int unsigned WIDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int unsigned ACC_W  = 6;
    localparam int unsigned OFF_W  = 5;
    localparam int unsigned CNT_W  = ADDR_W + 1;
    localparam logic [WIDX_W-1:0] LAST_WORD = WIDX_W'(WORDS - 1);

    typedef enum logic {
        S_RUN   = 1'b0,
        S_DRAIN = 1'b1
    } state_e;

    state_e              state_q,     state_d;
    logic [ACC_W-1:0]    bit_acc_q,   bit_acc_d;
    logic [WIDX_W-1:0]   word_idx_q,  word_idx_d;
    logic [CNT_W-1:0]    run_cnt_q,   run_cnt_d;
    logic                opt_valid_q, opt_valid_d;
    logic [ADDR_W-1:0]   addr_q,      addr_d;
    logic                step_done_q, step_done_d;
    logic [CNT_W-1:0]    spk_cnt_q,   spk_cnt_d;

    logic                is_end_c;
    logic [OFF_W-1:0]    off_c;
    logic [ACC_W-1:0]    sum_c;
    logic                tok_acc_c;

    // Token field split and running bit position of the candidate spike
    assign is_end_c  = enc[5];
    assign off_c     = enc[4:0];
    assign sum_c     = bit_acc_q + ACC_W'(off_c);
    assign tok_acc_c = ipt_valid && ipt_ready;

    // Next-state, output-register load and handshake decode
    always_comb begin
        state_d     = state_q;
        bit_acc_d   = bit_acc_q;
        word_idx_d  = word_idx_q;
        run_cnt_d   = run_cnt_q;
        opt_valid_d = opt_valid_q;
        addr_d      = addr_q;
        step_done_d = 1'b0;
        spk_cnt_d   = spk_cnt_q;
        ipt_ready   = 1'b0;

        // A retiring output empties the register unless a new load overrides below
        if (opt_ready) begin
            opt_valid_d = 1'b0;
        end

        case (state_q)
            S_RUN: begin
                ipt_ready = !opt_valid_q || opt_ready;
                if (ipt_valid && (!opt_valid_q || opt_ready)) begin
                    if (!is_end_c) begin
                        addr_d      = ADDR_W'({word_idx_q, sum_c[4:0]});
                        opt_valid_d = 1'b1;
                        bit_acc_d   = sum_c;
                        run_cnt_d   = run_cnt_q + CNT_W'(1);
                    end else begin
                        bit_acc_d = '0;
                        if (word_idx_q == LAST_WORD) begin
                            word_idx_d = '0;
                            state_d    = S_DRAIN;
                        end else begin
                            word_idx_d = word_idx_q + WIDX_W'(1);
                        end
                    end
                end
            end
            S_DRAIN: begin
                // Timestep closes once the last address has left the output register
                if (!opt_valid_q || opt_ready) begin
                    step_done_d = 1'b1;
                    spk_cnt_d   = run_cnt_q;
                    run_cnt_d   = '0;
                    state_d     = S_RUN;
                end
            end
            default: begin
                state_d = S_RUN;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_RUN;
            bit_acc_q   <= '0;
            word_idx_q  <= '0;
            run_cnt_q   <= '0;
            opt_valid_q <= 1'b0;
            addr_q      <= '0;
            step_done_q <= 1'b0;
            spk_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            bit_acc_q   <= bit_acc_d;
            word_idx_q  <= word_idx_d;
            run_cnt_q   <= run_cnt_d;
            opt_valid_q <= opt_valid_d;
            addr_q      <= addr_d;
            step_done_q <= step_done_d;
            spk_cnt_q   <= spk_cnt_d;
        end
    end

    assign opt_valid = opt_valid_q;
    assign addr      = addr_q;
    assign step_done = step_done_q;
    assign spk_cnt   = spk_cnt_q;

`ifdef SPK_IDX_DEC_CHK_EN
    logic first_q,   first_d;
    logic fmt_err_q, fmt_err_d;

    // Sticky detection of overflowing, duplicate or badly terminated words
    always_comb begin
        first_d   = first_q;
        fmt_err_d = fmt_err_q;
        if (tok_acc_c) begin
            if (!is_end_c) begin
                first_d = 1'b0;
                if (sum_c[5] || (!first_q && (off_c == '0))) begin
                    fmt_err_d = 1'b1;
                end
            end else begin
                first_d = 1'b1;
                if ((7'(bit_acc_q) + 7'(off_c)) != 7'd31) begin
                    fmt_err_d = 1'b1;
                end
            end
        end
    end

    // Check-state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            first_q   <= 1'b1;
            fmt_err_q <= 1'b0;
        end else begin
            first_q   <= first_d;
            fmt_err_q <= fmt_err_d;
        end
    end

    assign fmt_err = fmt_err_q;
`else
    logic unused_c;

    // Accept strobe only feeds the checker; keep it referenced when that is absent
    assign unused_c = tok_acc_c;
    assign fmt_err  = 1'b0;
`endif

endmodule

// File: tb/tb_spk_idx_dec.sv
// Bench for spk_idx_dec: instance 0 uses WORDS=1, instance 1 uses WORDS=2.
// A token-level model predicts addresses, spike counts and fmt_err; literal
// checks pin the directed scenarios.
module tb_spk_idx_dec;

`ifdef SPK_IDX_DEC_CHK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;

    logic [1:0]      ipt_valid;
    logic [1:0]      ipt_ready;
    logic [1:0][5:0] enc;
    logic [1:0]      opt_valid;
    logic [1:0]      opt_ready;
    logic [1:0][7:0] addr;
    logic [1:0]      step_done;
    logic [1:0][8:0] spk_cnt;
    logic [1:0]      fmt_err;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Model state per instance
    int words_of [2] = '{1, 2};
    int m_acc    [2];
    int m_widx   [2];
    int m_cnt    [2];
    bit m_first  [2];
    bit m_err    [2];
    int exp_addr [2][$];
    int exp_cnt  [2][$];

    // Observation logs for literal checks
    int got_addr  [2][$];
    int addr_cyc  [2][$];
    int got_cnt   [2][$];
    int done_cyc  [2][$];

    logic [1:0]      hold_pend;
    logic [1:0][7:0] hold_addr;

    spk_idx_dec #(.WORDS(1), .ADDR_W(8)) u_dut0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .ipt_valid (ipt_valid[0]),
        .ipt_ready (ipt_ready[0]),
        .enc       (enc[0]),
        .opt_valid (opt_valid[0]),
        .opt_ready (opt_ready[0]),
        .addr      (addr[0]),
        .step_done (step_done[0]),
        .spk_cnt   (spk_cnt[0]),
        .fmt_err   (fmt_err[0])
    );

    spk_idx_dec #(.WORDS(2), .ADDR_W(8)) u_dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .ipt_valid (ipt_valid[1]),
        .ipt_ready (ipt_ready[1]),
        .enc       (enc[1]),
        .opt_valid (opt_valid[1]),
        .opt_ready (opt_ready[1]),
        .addr      (addr[1]),
        .step_done (step_done[1]),
        .spk_cnt   (spk_cnt[1]),
        .fmt_err   (fmt_err[1])
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int d, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s inst%0d got=%0d exp=%0d (cycle %0d)", name, d, got, exp, cyc);
        end
    endtask

    // Apply one accepted token to the model
    task automatic model_accept(input int d, input logic [5:0] tok);
        int off;
        int sum;
        bit hit;
        off = int'(tok[4:0]);
        hit = 1'b0;
        if (!tok[5]) begin
            sum = (m_acc[d] + off) % 64;
            if (sum > 31 || (!m_first[d] && off == 0)) hit = 1'b1;
            exp_addr[d].push_back(m_widx[d] * 32 + (sum % 32));
            m_acc[d]   = sum;
            m_first[d] = 1'b0;
            m_cnt[d]++;
        end else begin
            if (m_acc[d] + off != 31) hit = 1'b1;
            m_acc[d]   = 0;
            m_first[d] = 1'b1;
            if (m_widx[d] == words_of[d] - 1) begin
                m_widx[d] = 0;
                exp_cnt[d].push_back(m_cnt[d]);
                m_cnt[d] = 0;
            end else begin
                m_widx[d]++;
            end
        end
        if (CHK && hit) m_err[d] = 1'b1;
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_acc[d]   = 0;
            m_widx[d]  = 0;
            m_cnt[d]   = 0;
            m_first[d] = 1'b1;
            m_err[d]   = 1'b0;
            exp_addr[d].delete();
            exp_cnt[d].delete();
        end
    endtask

    task automatic clear_logs();
        for (int d = 0; d < 2; d++) begin
            got_addr[d].delete();
            addr_cyc[d].delete();
            got_cnt[d].delete();
            done_cyc[d].delete();
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        cycles(2);
        rst_n = 1'b1;
        cycles(1);
    endtask

    // Present one token (caller is just past a rising edge) and wait for acceptance
    task automatic send(input int d, input logic [5:0] tok);
        int n;
        n = 0;
        ipt_valid[d] = 1'b1;
        enc[d]       = tok;
        @(negedge clk);
        while (!ipt_ready[d] && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!ipt_ready[d]) begin
            check("accept_timeout", d, 0, 1);
            ipt_valid[d] = 1'b0;
            cycles(1);
            return;
        end
        @(posedge clk);
        model_accept(d, tok);
        #1;
        ipt_valid[d] = 1'b0;
    endtask

    // Per-cycle comparison of both instances against the model
    always @(negedge clk) begin
        if (!rst_n) begin
            hold_pend = '0;
        end else begin
            for (int d = 0; d < 2; d++) begin
                check("fmt_err", d, fmt_err[d], m_err[d]);
                if (hold_pend[d]) begin
                    check("hold_valid", d, opt_valid[d], 1);
                    check("hold_addr", d, addr[d], hold_addr[d]);
                end
                hold_pend[d] = opt_valid[d] && !opt_ready[d];
                hold_addr[d] = addr[d];
                if (opt_valid[d] && opt_ready[d]) begin
                    got_addr[d].push_back(int'(addr[d]));
                    addr_cyc[d].push_back(cyc);
                    check("addr_expected", d, int'(exp_addr[d].size() > 0), 1);
                    if (exp_addr[d].size() > 0) check("addr", d, addr[d], exp_addr[d].pop_front());
                end
                if (step_done[d]) begin
                    got_cnt[d].push_back(int'(spk_cnt[d]));
                    done_cyc[d].push_back(cyc);
                    check("step_done_expected", d, int'(exp_cnt[d].size() > 0), 1);
                    if (exp_cnt[d].size() > 0) check("spk_cnt", d, spk_cnt[d], exp_cnt[d].pop_front());
                end
            end
        end
    end

    initial begin
        ipt_valid = '0;
        enc       = '0;
        opt_ready = 2'b11;
        rst_n     = 1'b0;
        model_reset();
        cycles(2);

        // Reset state
        for (int d = 0; d < 2; d++) begin
            check("rst_opt_valid", d, opt_valid[d], 0);
            check("rst_addr", d, addr[d], 0);
            check("rst_step_done", d, step_done[d], 0);
            check("rst_spk_cnt", d, spk_cnt[d], 0);
            check("rst_fmt_err", d, fmt_err[d], 0);
        end
        rst_n = 1'b1;
        cycles(1);
        check("rst_ipt_ready", 0, ipt_ready[0], 1);

        // WORDS=1 basic word: 0,5,31 then end
        clear_logs();
        send(0, 6'h00); send(0, 6'h05); send(0, 6'h1A); send(0, 6'h20);
        cycles(6);
        check("t1_n_addr", 0, got_addr[0].size(), 3);
        if (got_addr[0].size() == 3) begin
            check("t1_addr0", 0, got_addr[0][0], 0);
            check("t1_addr1", 0, got_addr[0][1], 5);
            check("t1_addr2", 0, got_addr[0][2], 31);
        end
        check("t1_n_done", 0, got_cnt[0].size(), 1);
        if (got_cnt[0].size() == 1 && addr_cyc[0].size() == 3) begin
            check("t1_spk_cnt", 0, got_cnt[0][0], 3);
            check("t1_done_lat", 0, done_cyc[0][0] - addr_cyc[0][2], 2);
        end
        check("t1_fmt_err", 0, fmt_err[0], 0);

        // WORDS=2: empty word then one spike at bit 3 of word 1
        clear_logs();
        send(1, 6'h3F); send(1, 6'h03); send(1, 6'h3C);
        cycles(6);
        check("t2_n_addr", 1, got_addr[1].size(), 1);
        if (got_addr[1].size() == 1) check("t2_addr", 1, got_addr[1][0], 35);
        check("t2_n_done", 1, got_cnt[1].size(), 1);
        if (got_cnt[1].size() == 1) check("t2_spk_cnt", 1, got_cnt[1][0], 1);

        // Backpressure: hold addr 2 for three cycles with the next token pending
        clear_logs();
        opt_ready[0] = 1'b0;
        fork
            begin
                send(0, 6'h02); send(0, 6'h04); send(0, 6'h39);
            end
            begin
                int n;
                n = 0;
                @(negedge clk);
                while (!opt_valid[0] && n < 20) begin
                    @(negedge clk);
                    n++;
                end
                for (int i = 0; i < 3; i++) begin
                    check("bp_valid", 0, opt_valid[0], 1);
                    check("bp_addr", 0, addr[0], 2);
                    check("bp_ipt_ready", 0, ipt_ready[0], 0);
                    if (i < 2) @(negedge clk);
                end
                @(posedge clk);
                #1;
                opt_ready[0] = 1'b1;
            end
        join
        cycles(6);
        check("t3_n_addr", 0, got_addr[0].size(), 2);
        if (got_addr[0].size() == 2) begin
            check("t3_addr0", 0, got_addr[0][0], 2);
            check("t3_addr1", 0, got_addr[0][1], 6);
        end
        check("t3_n_done", 0, got_cnt[0].size(), 1);
        if (got_cnt[0].size() == 1) check("t3_spk_cnt", 0, got_cnt[0][0], 2);

        // Bad end token: 5 + 1 != 31
        clear_logs();
        send(0, 6'h05); send(0, 6'h21);
        cycles(5);
        check("t4_fmt_err", 0, fmt_err[0], CHK);
        check("t4_n_done", 0, got_cnt[0].size(), 1);
        if (got_cnt[0].size() == 1) check("t4_spk_cnt", 0, got_cnt[0][0], 1);
        cycles(3);
        check("t4_fmt_err_sticky", 0, fmt_err[0], CHK);

        // Reset mid-word discards the partial word
        clear_logs();
        send(0, 6'h04); send(0, 6'h01);
        do_reset();
        check("t5_rst_valid", 0, opt_valid[0], 0);
        check("t5_rst_fmt_err", 0, fmt_err[0], 0);
        clear_logs();
        send(0, 6'h07); send(0, 6'h38);
        cycles(6);
        check("t5_n_addr", 0, got_addr[0].size(), 1);
        if (got_addr[0].size() == 1) check("t5_addr", 0, got_addr[0][0], 7);
        check("t5_n_done", 0, got_cnt[0].size(), 1);
        if (got_cnt[0].size() == 1) check("t5_spk_cnt", 0, got_cnt[0][0], 1);

        // Back-to-back timesteps: empty step then one spike at bit 0
        clear_logs();
        send(0, 6'h3F); send(0, 6'h00); send(0, 6'h3F);
        cycles(6);
        check("t6_n_done", 0, got_cnt[0].size(), 2);
        if (got_cnt[0].size() == 2) begin
            check("t6_spk_cnt0", 0, got_cnt[0][0], 0);
            check("t6_spk_cnt1", 0, got_cnt[0][1], 1);
        end
        check("t6_n_addr", 0, got_addr[0].size(), 1);
        if (got_addr[0].size() == 1) check("t6_addr", 0, got_addr[0][0], 0);

        // Nothing predicted may be left outstanding
        for (int d = 0; d < 2; d++) begin
            check("left_addr", d, exp_addr[d].size(), 0);
            check("left_done", d, exp_cnt[d].size(), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
